// File: rtl/dla_pkg.sv
// dla_pkg: shared direction/state enums and default grid size for the DLA walker
package dla_pkg;
   localparam int H_SIZE_DEF = 640;
   localparam int V_SIZE_DEF = 480;
   typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;
   typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_STEP, ST_WRITE, ST_DONE} state_e;
endpackage

// File: rtl/dla_neighbor_gen.sv
// dla_neighbor_gen: neighbour coordinate of (x,y) in a direction and whether it lies on the grid
module dla_neighbor_gen
   import dla_pkg::*;
#(
   parameter int H_SIZE = H_SIZE_DEF,
   parameter int V_SIZE = V_SIZE_DEF,
   parameter int XW     = $clog2(H_SIZE),
   parameter int YW     = $clog2(V_SIZE)
) (
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   input  dir_e          i_dir,
   output logic [XW-1:0] o_nx,
   output logic [YW-1:0] o_ny,
   output logic          o_ok
);
   always_comb begin
      o_nx = (i_dir == DIR_E) ? i_x + XW'(1) : (i_dir == DIR_W) ? i_x - XW'(1) : i_x;
      o_ny = (i_dir == DIR_S) ? i_y + YW'(1) : (i_dir == DIR_N) ? i_y - YW'(1) : i_y;
      o_ok = (i_dir == DIR_N) ? (i_y != '0) :
             (i_dir == DIR_E) ? (i_x != XW'(H_SIZE - 1)) :
             (i_dir == DIR_S) ? (i_y != YW'(V_SIZE - 1)) : (i_x != '0);
   end
endmodule

// File: rtl/dla_walker.sv
// dla_walker: random-walk particle that scans neighbours, steps from LFSR bits and sticks on contact
module dla_walker
   import dla_pkg::*;
#(
   parameter int H_SIZE    = H_SIZE_DEF,
   parameter int V_SIZE    = V_SIZE_DEF,
   parameter int RND_WIDTH = 16,
   parameter int MAX_STEPS = 65535,
   parameter int XW        = $clog2(H_SIZE),
   parameter int YW        = $clog2(V_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [XW-1:0]        start_x,
   input  logic [YW-1:0]        start_y,
   input  logic [RND_WIDTH-1:0] rnd_value,
   output logic                 rnd_shift,
   output logic                 rd_req,
   output logic [XW-1:0]        rd_x,
   output logic [YW-1:0]        rd_y,
   input  logic                 rd_ack,
   input  logic                 rd_data,
   output logic                 wr_req,
   output logic [XW-1:0]        wr_x,
   output logic [YW-1:0]        wr_y,
   input  logic                 wr_ack,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [XW-1:0]        final_x,
   output logic [YW-1:0]        final_y
);
   state_e          r_state, w_next;
   dir_e            r_idx;
   logic [XW-1:0]   r_x, r_final_x, w_nb_x, w_mv_x;
   logic [YW-1:0]   r_y, r_final_y, w_nb_y, w_mv_y;
   logic [15:0]     r_steps;
   logic            r_timeout, w_nb_ok, w_mv_ok, w_adv, w_hit, w_last, w_expired, w_unused;

   assign w_unused = ^rnd_value[RND_WIDTH-1:2];

   dla_neighbor_gen #(.H_SIZE(H_SIZE), .V_SIZE(V_SIZE), .XW(XW), .YW(YW)) u_scan (
      .i_x(r_x), .i_y(r_y), .i_dir(r_idx), .o_nx(w_nb_x), .o_ny(w_nb_y), .o_ok(w_nb_ok)
   );

   // The move target reuses the neighbour logic: the LFSR bits index the same N/E/S/W order
   dla_neighbor_gen #(.H_SIZE(H_SIZE), .V_SIZE(V_SIZE), .XW(XW), .YW(YW)) u_move (
      .i_x(r_x), .i_y(r_y), .i_dir(dir_e'(rnd_value[1:0])), .o_nx(w_mv_x), .o_ny(w_mv_y), .o_ok(w_mv_ok)
   );

   assign w_adv     = (r_state == ST_CHECK) && (!w_nb_ok || (rd_ack && !rd_data));
   assign w_hit     = (r_state == ST_CHECK) && w_nb_ok && rd_ack && rd_data;
   assign w_last    = w_adv && (r_idx == DIR_W);
   assign w_expired = (r_steps == 16'(MAX_STEPS));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  w_next = start ? ST_CHECK : ST_IDLE;
         ST_CHECK: w_next = w_hit ? ST_WRITE : w_last ? (w_expired ? ST_DONE : ST_STEP) : ST_CHECK;
         ST_STEP:  w_next = ST_CHECK;
         ST_WRITE: w_next = wr_ack ? ST_DONE : ST_WRITE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x       <= '0;
         r_y       <= '0;
         r_idx     <= DIR_N;
         r_steps   <= '0;
         r_timeout <= 1'b0;
         r_final_x <= '0;
         r_final_y <= '0;
      end else begin
         if (r_state == ST_IDLE && start) begin
            r_x       <= start_x;
            r_y       <= start_y;
            r_idx     <= DIR_N;
            r_steps   <= '0;
            r_timeout <= 1'b0;
         end
         if (w_adv) r_idx <= dir_e'(r_idx + 2'd1);
         if (w_last && w_expired) r_timeout <= 1'b1;
         if (r_state == ST_STEP) begin
            r_steps <= r_steps + 16'd1;
            if (w_mv_ok) begin
               r_x <= w_mv_x;
               r_y <= w_mv_y;
            end
         end
         if (r_state == ST_DONE) begin
            r_final_x <= r_x;
            r_final_y <= r_y;
         end
      end
   end

   always_comb begin
      busy      = (r_state != ST_IDLE);
      done      = (r_state == ST_DONE);
      rnd_shift = (r_state == ST_STEP);
      rd_req    = (r_state == ST_CHECK) && w_nb_ok;
      rd_x      = ((r_state == ST_CHECK) && w_nb_ok) ? w_nb_x : '0;
      rd_y      = ((r_state == ST_CHECK) && w_nb_ok) ? w_nb_y : '0;
      wr_req    = (r_state == ST_WRITE);
      wr_x      = (r_state == ST_WRITE) ? r_x : '0;
      wr_y      = (r_state == ST_WRITE) ? r_y : '0;
      timeout   = r_timeout;
      final_x   = r_final_x;
      final_y   = r_final_y;
   end
endmodule

// File: tb/tb_dla_walker.sv
// tb_dla_walker: directed checks of the walker on an 8x8 grid with a three-step budget
module tb_dla_walker;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [2:0]  start_x = '0, start_y = '0;
   logic [15:0] rnd_value = '0;
   logic        rnd_shift, rd_req, rd_ack, rd_data, wr_req, wr_ack, busy, done, timeout;
   logic [2:0]  rd_x, rd_y, wr_x, wr_y, final_x, final_y;
   logic        ack_rd = 1'b0, ack_wr = 1'b0;
   logic        occ [0:63];
   int          n_assert = 0, n_fail = 0;
   int          cyc, shifts, wreqs, bad;

   dla_walker #(.H_SIZE(8), .V_SIZE(8), .RND_WIDTH(16), .MAX_STEPS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .start_x(start_x), .start_y(start_y),
      .rnd_value(rnd_value), .rnd_shift(rnd_shift),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ack(rd_ack), .rd_data(rd_data),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_ack(wr_ack),
      .busy(busy), .done(done), .timeout(timeout), .final_x(final_x), .final_y(final_y)
   );

   assign rd_ack  = ack_rd;
   assign wr_ack  = ack_wr;
   assign rd_data = occ[{rd_y, rd_x}];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_grid;
      for (int i = 0; i < 64; i++) occ[i] = 1'b0;
   endtask

   task automatic launch(input int x, input int y);
      start_x = 3'(x);
      start_y = 3'(y);
      start   = 1'b1;
      tick;
      start   = 1'b0;
   endtask

   task automatic run_to_done(input int c0, output int c_done, output int n_sh, output int n_wr);
      c_done = -1;
      n_sh   = 0;
      n_wr   = 0;
      for (int c = c0; c < c0 + 100; c++) begin
         n_sh += int'(rnd_shift);
         n_wr += int'(wr_req);
         if (done) begin
            c_done = c;
            break;
         end
         tick;
      end
   endtask

   initial begin
      clear_grid;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_wr_req", wr_req, 0);
      chk("rst_done", done, 0);
      chk("rst_final_x", final_x, 0);
      tick;
      rst = 1'b1;
      tick;
      // reset asserted mid-CHECK while the read is stalled
      launch(3, 3);
      chk("a_busy", busy, 1);
      chk("a_rd_req", rd_req, 1);
      chk("a_rd_y", rd_y, 2);
      #2;
      rst = 1'b0;
      #1;
      chk("a_async_rd_req", rd_req, 0);
      chk("a_async_busy", busy, 0);
      chk("a_async_shift", rnd_shift, 0);
      chk("a_async_rd_y", rd_y, 0);
      #2;
      rst = 1'b1;
      tick;
      chk("a_idle_after", busy, 0);
      // corner (0,0), every move north is blocked
      ack_rd = 1'b1;
      ack_wr = 1'b1;
      rnd_value = 16'h0000;
      launch(0, 0);
      chk("c_busy", busy, 1);
      chk("c_n_rd_req", rd_req, 0);
      tick;
      chk("c_e_rd_req", rd_req, 1);
      chk("c_e_rd_x", rd_x, 1);
      tick;
      chk("c_s_rd_y", rd_y, 1);
      tick;
      chk("c_w_rd_req", rd_req, 0);
      chk("c_w_shift", rnd_shift, 0);
      tick;
      chk("c_step_shift", rnd_shift, 1);
      tick;
      chk("c_shift_drop", rnd_shift, 0);
      chk("c_n2_rd_req", rd_req, 0);
      tick;
      chk("c_e2_rd_x", rd_x, 1);
      chk("c_e2_rd_y", rd_y, 0);
      run_to_done(7, cyc, shifts, wreqs);
      chk("c_done_cycle", cyc, 20);
      chk("c_shifts", shifts, 2);
      chk("c_timeout", timeout, 1);
      tick;
      chk("c_final_x", final_x, 0);
      chk("c_final_y", final_y, 0);
      chk("c_idle", busy, 0);
      // neighbour hit at (4,5) from (5,5)
      occ[5*8+4] = 1'b1;
      launch(5, 5);
      chk("b_timeout_cleared", timeout, 0);
      chk("b_n_x", rd_x, 5);
      chk("b_n_y", rd_y, 4);
      tick;
      chk("b_e_x", rd_x, 6);
      chk("b_e_y", rd_y, 5);
      tick;
      chk("b_s_x", rd_x, 5);
      chk("b_s_y", rd_y, 6);
      tick;
      chk("b_w_x", rd_x, 4);
      chk("b_w_y", rd_y, 5);
      tick;
      chk("b_wr_req", wr_req, 1);
      chk("b_wr_x", wr_x, 5);
      chk("b_wr_y", wr_y, 5);
      chk("b_rd_idle", rd_req, 0);
      tick;
      chk("b_done", done, 1);
      chk("b_timeout", timeout, 0);
      tick;
      chk("b_done_pulse", done, 0);
      chk("b_final_x", final_x, 5);
      chk("b_final_y", final_y, 5);
      // step budget exhausted walking east from (1,1)
      clear_grid;
      rnd_value = 16'hBEE1;
      launch(1, 1);
      run_to_done(1, cyc, shifts, wreqs);
      chk("d_done_cycle", cyc, 20);
      chk("d_shifts", shifts, 3);
      chk("d_no_wr", wreqs, 0);
      chk("d_timeout", timeout, 1);
      tick;
      chk("d_final_x", final_x, 4);
      chk("d_final_y", final_y, 1);
      // stalled read, then a start pulse while busy
      ack_rd = 1'b0;
      launch(2, 2);
      chk("e_rd_x", rd_x, 2);
      chk("e_rd_y", rd_y, 1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (rd_req !== 1'b1 || rd_x !== 3'd2 || rd_y !== 3'd1 || rnd_shift !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("e_stall_stable", bad, 0);
      ack_rd  = 1'b1;
      start_x = 3'd7;
      start_y = 3'd7;
      start   = 1'b1;
      tick;
      chk("e_next_x", rd_x, 3);
      chk("e_next_y", rd_y, 2);
      tick;
      start = 1'b0;
      run_to_done(0, cyc, shifts, wreqs);
      chk("f_done_seen", int'(cyc >= 0), 1);
      chk("f_shifts", shifts, 3);
      tick;
      chk("f_final_x", final_x, 5);
      chk("f_final_y", final_y, 2);
      chk("f_timeout", timeout, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/dla_walker.md
# dla_walker

Random-walk particle engine for the diffusion-limited aggregation demo. It consumes pseudo-random values from the LFSR by driving its `shift` input and reading its `value` output, then walks one particle across the frame buffer grid. When the particle touches an occupied pixel it writes itself into the frame buffer; if it walks too long without touching anything, it gives up. It sits between the LFSR and the frame-buffer arbiter and is sequenced by the DLA top-level controller.

## Interface
Parameters:
- `H_SIZE`, 640, grid width in pixels
- `V_SIZE`, 480, grid height in pixels
- `RND_WIDTH`, 16, width of random input
- `MAX_STEPS`, 65535, step budget per particle (1..65535)
- `XW` / `YW`, `$clog2(H_SIZE)` / `$clog2(V_SIZE)`, coordinate widths (derived)

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: launch particle; sampled only in IDLE
- `start_x` / `start_y` in XW / YW: launch position; must be in range
- `rnd_value` in RND_WIDTH: LFSR output
- `rnd_shift` out 1: LFSR advance strobe
- `rd_req` out 1: frame-buffer occupancy read request
- `rd_x` / `rd_y` out XW / YW: read address
- `rd_ack` in 1: read accepted
- `rd_data` in 1: pixel occupied; valid when `rd_ack` is high
- `wr_req` out 1: write (set pixel) request
- `wr_x` / `wr_y` out XW / YW: write address
- `wr_ack` in 1: write accepted
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle completion pulse
- `timeout` out 1: last particle expired without sticking; held until next accepted `start`
- `final_x` / `final_y` out XW / YW: last particle position; held until next accepted `start`

## Operation
- States: IDLE, CHECK, STEP, WRITE, DONE.
- IDLE:
  - On `start`, load pos=(start_x,start_y), clear step counter, clear `timeout`, then go to CHECK.
  - `start` in any other state is ignored.
- CHECK scans the neighbours in fixed order N (y-1), E (x+1), S (y+1), W (x-1), indexed 0..3.
  - In-range neighbour: drive `rd_req` with its address. On `rd_req && rd_ack`:
    - If `rd_data`=1, go to WRITE.
    - Otherwise go to the next index.
  - Out-of-range neighbour (x=0 W, x=H_SIZE-1 E, y=0 N, y=V_SIZE-1 S): spend one cycle with `rd_req` low, then go to the next index.
  - After index 3 with no hit: go to DONE with `timeout`=1 if step count == MAX_STEPS; otherwise go to STEP.
- STEP: one cycle.
  - Sample direction = `rnd_value[1:0]` (pre-shift value): 00 N, 01 E, 10 S, 11 W.
  - Assert `rnd_shift`.
  - Apply the move unless it leaves the grid. A blocked move leaves the position unchanged but still counts as a step.
  - Increment the step counter, then go to CHECK.
- WRITE: drive `wr_req` with `wr_x/wr_y`=pos until `wr_ack`, then go to DONE.
- DONE: pulse `done`, update `final_x/final_y`=pos, return to IDLE.
- Handshake rule: a request stays high with a stable address until acked. The transfer happens on the cycle `req && ack` is high. Requests are never withdrawn.
- Reset, including mid-operation: state=IDLE. All outputs are 0: `rd_req`, `wr_req`, `rnd_shift`, `busy`, `done`, `timeout`, addresses, and `final_x/final_y`.

## Timing
- `start` accepted at cycle 0 → `busy` and first CHECK slot at cycle 1.
- CHECK costs exactly 4 cycles when acks are immediate. Each wait cycle adds one. Out-of-range slots always cost 1 cycle.
- CHECK exits early on the first hit; remaining neighbours are not read.
- One walk step = 4 CHECK cycles + 1 STEP cycle with zero-wait acks.
- `rnd_shift` is high for exactly one cycle per step and never outside STEP.
- Hit on the last read at cycle t → `wr_req` at t+1. With an immediate `wr_ack`, `done` at t+2.
- `done` is followed by IDLE the next cycle, so `start` can be accepted the cycle after `done`.
- The step counter is 16 bits and never wraps, because MAX_STEPS ≤ 65535.

## Structure
- Shared package `dla_pkg`:
  - direction enum (N, E, S, W)
  - walker state enum
  - default `H_SIZE` / `V_SIZE` constants
- Sub-module `dla_neighbor_gen`: combinational neighbour address and in-range flag from pos and index.
- Everything else is one FSM plus counters in `dla_walker`.

## Test plan
- Reset mid-CHECK with `rd_ack` low: `rst` low → `rd_req`, `busy`, `rnd_shift` drop to 0 without waiting for a clock. After release, IDLE, and `start` is accepted.
- Grid 8x8, start (5,5), pixel (4,5) occupied, acks tied 1:
  - reads (5,4), (6,5), (5,6), (4,5) on cycles 1-4;
  - `wr_req` at (5,5) on cycle 5; `done` on cycle 6; `timeout`=0.
- Start (0,0), empty grid, `rnd_value`=0:
  - N and W slots show `rd_req` low;
  - each STEP keeps pos (0,0) and pulses `rnd_shift` once.
- MAX_STEPS=3, empty 8x8 grid, `rnd_value[1:0]`=01, start (1,1) → `done` with `timeout`=1, `final`=(4,1), `wr_req` never asserted.
- `rd_ack` held low 10 cycles in CHECK → `rd_req`, `rd_x/rd_y` stable, no state advance, no `rnd_shift`.
- `start` pulsed while `busy` → ignored; particle completes with its original position.
